// File: rtl/pwm_fade_sequencer.sv
// Pattern sequencer that feeds one-cycle impulses to a bank of LED fade channels.
// Runs chase, bounce, all-flash or single-sweep patterns at a latched step period.
module pwm_fade_sequencer #(
    parameter int NumChannels  = 8,
    parameter int StepCtrWidth = 24
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             en_i,
    input  logic [1:0]                       mode_i,
    input  logic [StepCtrWidth-1:0]          step_ticks_i,
    output logic [NumChannels-1:0]           impulse_o,
    output logic                             busy_o,
    output logic [$clog2(NumChannels)-1:0]   pos_o
);

    localparam int PosW = $clog2(NumChannels);
    localparam logic [PosW-1:0] LastPos = PosW'(NumChannels - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        ModeChase   = 2'd0,
        ModeBounce  = 2'd1,
        ModeAll     = 2'd2,
        ModeOneshot = 2'd3
    } mode_e;

    state_e                  state_q, state_d;
    mode_e                   mode_q, mode_d;
    logic [StepCtrWidth-1:0] period_q, period_d;
    logic [StepCtrWidth-1:0] cnt_q, cnt_d;
    logic [PosW-1:0]         pos_q, pos_d, step_pos;
    logic                    down_q, down_d, step_down;
    logic [NumChannels-1:0]  imp_q, imp_d, step_imp;
    logic                    busy_q, busy_d;

    // Next position/direction if a step fires this cycle.
    always_comb begin
        step_pos  = '0;
        step_down = down_q;
        unique case (mode_q)
            ModeAll: step_pos = '0;
            ModeBounce: begin
                if (!down_q) begin
                    if (pos_q == LastPos) begin
                        step_pos  = pos_q - 1'b1;
                        step_down = 1'b1;
                    end else begin
                        step_pos = pos_q + 1'b1;
                    end
                end else begin
                    if (pos_q == '0) begin
                        step_pos  = PosW'(1);
                        step_down = 1'b0;
                    end else begin
                        step_pos = pos_q - 1'b1;
                    end
                end
            end
            default: step_pos = (pos_q == LastPos) ? '0 : pos_q + 1'b1;
        endcase
        step_imp = (mode_q == ModeAll) ? '1 : (NumChannels'(1) << step_pos);
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        pos_d    = pos_q;
        down_d   = down_q;
        imp_d    = '0;
        unique case (state_q)
            StIdle: begin
                if (en_i) begin
                    state_d  = StRun;
                    mode_d   = mode_e'(mode_i);
                    period_d = step_ticks_i;
                    cnt_d    = step_ticks_i;
                    pos_d    = '0;
                    down_d   = 1'b0;
                    imp_d    = (mode_e'(mode_i) == ModeAll) ? '1 : NumChannels'(1);
                end
            end
            StRun: begin
                // Disable beats any step due on the same edge.
                if (!en_i) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    pos_d   = '0;
                    down_d  = 1'b0;
                end else if (mode_q == ModeOneshot && pos_q == LastPos) begin
                    state_d = StDone;
                end else if (cnt_q == '0) begin
                    cnt_d  = period_q;
                    pos_d  = step_pos;
                    down_d = step_down;
                    imp_d  = step_imp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                if (!en_i) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    pos_d   = '0;
                    down_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d == StRun);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            mode_q   <= ModeChase;
            period_q <= '0;
            cnt_q    <= '0;
            pos_q    <= '0;
            down_q   <= 1'b0;
            imp_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            pos_q    <= pos_d;
            down_q   <= down_d;
            imp_q    <= imp_d;
            busy_q   <= busy_d;
        end
    end

    assign impulse_o = imp_q;
    assign busy_o    = busy_q;
    assign pos_o     = pos_q;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Bench for pwm_fade_sequencer: step-count model checked every cycle,
// plus directed literal checks on the documented sequences.
module tb_pwm_fade_sequencer;

    localparam int N  = 8;
    localparam int SW = 24;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          en_i;
    logic [1:0]    mode_i;
    logic [SW-1:0] step_ticks_i;
    logic [N-1:0]  impulse_o;
    logic          busy_o;
    logic [2:0]    pos_o;

    int n_tests = 0;
    int n_fail  = 0;

    int m_phase = 0;
    int m_mode  = 0;
    int m_per   = 0;
    int m_el    = 0;
    int m_n     = 0;
    logic [N-1:0] exp_imp  = '0;
    logic         exp_busy = 1'b0;
    int           exp_pos  = 0;

    int bt[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

    pwm_fade_sequencer #(
        .NumChannels (N),
        .StepCtrWidth(SW)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .mode_i      (mode_i),
        .step_ticks_i(step_ticks_i),
        .impulse_o   (impulse_o),
        .busy_o      (busy_o),
        .pos_o       (pos_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int pat_pos(int mode, int n);
        int r;
        if (mode == 2) return 0;
        if (mode == 1) begin
            r = n % (2 * N - 2);
            return (r < N) ? r : (2 * N - 2 - r);
        end
        return n % N;
    endfunction

    function automatic logic [N-1:0] pat_imp(int mode, int n);
        logic [N-1:0] one;
        if (mode == 2) return '1;
        one = 1;
        return one << pat_pos(mode, n);
    endfunction

    // Model: step n fires every (period+1) cycles after the start edge.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_phase  <= 0;
            exp_imp  <= '0;
            exp_busy <= 1'b0;
            exp_pos  <= 0;
        end else begin
            case (m_phase)
                0: begin
                    exp_imp  <= '0;
                    exp_busy <= 1'b0;
                    exp_pos  <= 0;
                    if (en_i) begin
                        m_phase  <= 1;
                        m_mode   <= int'(mode_i);
                        m_per    <= int'(step_ticks_i);
                        m_el     <= 0;
                        m_n      <= 0;
                        exp_imp  <= pat_imp(int'(mode_i), 0);
                        exp_busy <= 1'b1;
                        exp_pos  <= 0;
                    end
                end
                1: begin
                    exp_imp <= '0;
                    if (!en_i) begin
                        m_phase  <= 0;
                        exp_busy <= 1'b0;
                        exp_pos  <= 0;
                    end else if (m_mode == 3 && m_n == N - 1) begin
                        m_phase  <= 2;
                        exp_busy <= 1'b0;
                    end else begin
                        m_el <= m_el + 1;
                        if ((m_el + 1) % (m_per + 1) == 0) begin
                            m_n     <= m_n + 1;
                            exp_imp <= pat_imp(m_mode, m_n + 1);
                            exp_pos <= pat_pos(m_mode, m_n + 1);
                        end
                    end
                end
                default: begin
                    exp_imp <= '0;
                    if (!en_i) begin
                        m_phase <= 0;
                        exp_pos <= 0;
                    end
                end
            endcase
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        check("model impulse", 32'(impulse_o), 32'(exp_imp));
        check("model busy", 32'(busy_o), 32'(exp_busy));
        check("model pos", 32'(pos_o), exp_pos);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni       = 1'b0;
        en_i         = 1'b0;
        mode_i       = 2'd0;
        step_ticks_i = '0;
        repeat (3) tick();
        check("reset impulse", 32'(impulse_o), 32'h0);
        check("reset busy", 32'(busy_o), 32'h0);
        check("reset pos", 32'(pos_o), 32'h0);
        rst_ni = 1'b1;

        // CHASE, period 3
        mode_i = 2'd0; step_ticks_i = 3; en_i = 1'b1;
        tick();
        check("chase c1", 32'(impulse_o), 32'h01);
        check("chase busy", 32'(busy_o), 32'h1);
        repeat (4) tick();
        check("chase c5", 32'(impulse_o), 32'h02);
        repeat (24) tick();
        check("chase c29", 32'(impulse_o), 32'h80);
        repeat (4) tick();
        check("chase c33", 32'(impulse_o), 32'h01);
        en_i = 1'b0;
        tick();

        // BOUNCE, period 0
        mode_i = 2'd1; step_ticks_i = 0; en_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("bounce pos", 32'(pos_o), bt[i]);
            check("bounce onehot", $countones(impulse_o), 1);
        end
        en_i = 1'b0;
        tick();

        // ALL, period 2; mid-run period change ignored
        mode_i = 2'd2; step_ticks_i = 2; en_i = 1'b1;
        tick();
        check("all c1", 32'(impulse_o), 32'hFF);
        tick();
        check("all c2", 32'(impulse_o), 32'h00);
        tick();
        check("all c3", 32'(impulse_o), 32'h00);
        tick();
        check("all c4", 32'(impulse_o), 32'hFF);
        step_ticks_i = 9;
        repeat (3) tick();
        check("all c7", 32'(impulse_o), 32'hFF);
        repeat (6) tick();
        en_i = 1'b0;
        tick();

        // ONESHOT, period 1
        mode_i = 2'd3; step_ticks_i = 1; en_i = 1'b1;
        tick();
        check("oneshot c1", 32'(impulse_o), 32'h01);
        repeat (14) tick();
        check("oneshot c15", 32'(impulse_o), 32'h80);
        check("oneshot busy c15", 32'(busy_o), 32'h1);
        tick();
        check("oneshot busy c16", 32'(busy_o), 32'h0);
        check("oneshot imp c16", 32'(impulse_o), 32'h0);
        repeat (10) tick();
        check("oneshot hold", 32'(busy_o), 32'h0);
        en_i = 1'b0;
        tick();
        en_i = 1'b1;
        tick();
        check("oneshot restart", 32'(impulse_o), 32'h01);
        check("oneshot restart busy", 32'(busy_o), 32'h1);
        en_i = 1'b0;
        tick();

        // Disable on the counter-zero cycle
        mode_i = 2'd0; step_ticks_i = 3; en_i = 1'b1;
        tick();
        repeat (7) tick();
        check("collide pos before", 32'(pos_o), 32'h1);
        en_i = 1'b0;
        tick();
        check("collide impulse", 32'(impulse_o), 32'h0);
        check("collide busy", 32'(busy_o), 32'h0);
        check("collide pos", 32'(pos_o), 32'h0);

        // Asynchronous reset mid-run
        en_i = 1'b1;
        tick();
        repeat (5) tick();
        #2 rst_ni = 1'b0;
        #1;
        check("async rst impulse", 32'(impulse_o), 32'h0);
        check("async rst busy", 32'(busy_o), 32'h0);
        check("async rst pos", 32'(pos_o), 32'h0);
        tick();
        rst_ni = 1'b1;
        tick();
        check("rst restart", 32'(impulse_o), 32'h01);
        repeat (4) tick();
        check("rst restart c5", 32'(impulse_o), 32'h02);
        en_i = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_fade_sequencer.md
# pwm_fade_sequencer

Pattern controller for a bank of `NumChannels` LED fade channels. It generates one-cycle impulses on a per-channel output vector, one fade channel per bit, and steps through chase, bounce, all-flash or single-sweep patterns at a programmable step period. It sits between the GPIO/LED control registers and the fade channel instances, and is their only source of impulses.

## Interface
- `NumChannels`, default 8: number of impulse outputs; must be ≥ 2.
- `StepCtrWidth`, default 24: width of the step period counter.
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `en_i`  in  1  run enable; level-sensitive.
- `mode_i`  in  2  pattern select: 0 CHASE, 1 BOUNCE, 2 ALL, 3 ONESHOT.
- `step_ticks_i`  in  `StepCtrWidth`  step period minus one, in clk_i cycles.
- `impulse_o`  out  `NumChannels`  registered one-cycle impulses, one bit per fade channel.
- `busy_o`  out  1  high while the FSM is in RUN.
- `pos_o`  out  `$clog2(NumChannels)`  index of the channel most recently pulsed.

## Operation
- FSM states: IDLE, RUN, DONE. After reset the FSM is in IDLE.
- IDLE → RUN on the first edge where `en_i` = 1. On that edge the block:
  - latches `mode_i` into `mode_q` and `step_ticks_i` into `period_q`;
  - loads the step counter with `period_q`;
  - sets position = 0 and direction = up;
  - issues the first impulse.
- While in RUN, `mode_i` and `step_ticks_i` are ignored. They take effect only at the next start.
- In RUN the step counter decrements each cycle. When it is 0, the block issues an impulse, advances the position and reloads the counter with `period_q`. Impulse spacing is therefore `period_q`+1 cycles.
- Impulse pattern per step, by mode:
  - CHASE: pulse bit `pos` only. `pos` goes 0,1,…,N-1,0,… and wraps.
  - BOUNCE: pulse bit `pos` only. `pos` goes 0,1,…,N-1,N-2,…,1,0,1,… Direction flips at each end, and no endpoint is pulsed twice in a row.
  - ALL: every bit of `impulse_o` is pulsed on every step. `pos` stays 0.
  - ONESHOT: same sequence as CHASE, but after the impulse on channel N-1 the FSM goes to DONE and issues no more impulses.
- DONE → IDLE when `en_i` = 0. Deasserting `en_i` in RUN also returns the FSM to IDLE on the next edge. Any impulse scheduled for that edge is suppressed. Position, direction and counter are cleared.
- A new start requires `en_i` to be observed as 0 (IDLE) and then 1 again. ONESHOT does not retrigger while `en_i` stays high.
- `pos_o` reflects the channel of the last impulse. It reads 0 in IDLE.

## Timing
- Reset values:
  - `impulse_o` = 0, `busy_o` = 0, `pos_o` = 0;
  - FSM in IDLE, counter = 0, direction = up.
- Reset asserted mid-operation returns every register to these values immediately (asynchronously).
- All outputs are registered; there is no combinational path from input to output.
- Start latency: `en_i` is sampled high at edge k. `impulse_o[0]` and `busy_o` are both high in cycle k+1.
- Each impulse lasts exactly one cycle. Consecutive impulses have their rising edges `period_q`+1 cycles apart.
- `period_q` = 0 is legal and gives an impulse on every cycle. In ALL mode with `period_q` = 0, `impulse_o` is held all-ones.
- Width rules:
  - the step counter is `StepCtrWidth` bits and reloads from `period_q` only, never from `step_ticks_i` directly;
  - position arithmetic wraps modulo NumChannels, including for non-power-of-two values.
- When the counter is 0 and `en_i` falls in the same cycle, disable wins: no impulse is issued and the next state is IDLE.
- ONESHOT: `busy_o` falls in the cycle after the channel N-1 impulse.

## Test plan
- Reset and CHASE: N=8, `step_ticks_i`=3, `en_i` high at cycle 0.
  - `impulse_o` = 0x01 at cycle 1, then 0x02 at cycle 5, 0x04 at cycle 9, …, 0x80 at cycle 29, then 0x01 again at cycle 33.
  - Every output is 0 while `rst_ni` is low.
- BOUNCE, N=4, `step_ticks_i`=0: `pos_o` sequence is 0,1,2,3,2,1,0,1 on consecutive cycles. There is exactly one impulse bit per cycle.
- ALL with `step_ticks_i`=2: `impulse_o` = 0xFF every third cycle and 0 otherwise. Changing `step_ticks_i` mid-run to 9 has no effect until the block is restarted.
- ONESHOT, N=8, `step_ticks_i`=1:
  - eight single-bit impulses, 0x01 through 0x80, on cycles 1,3,…,15;
  - `busy_o` is low from cycle 16 with no further impulses while `en_i` stays high;
  - after `en_i` low for 1 cycle then high again, a new sweep starts.
- Disable collision: drop `en_i` in the cycle where the counter is 0. There is no impulse, the FSM is in IDLE, and `pos_o` = 0 on the next cycle.
- Reset mid-run: assert `rst_ni` low during a CHASE step. Outputs clear at once. After release with `en_i` high, the sequence restarts at channel 0.
